// File: rtl/memory_initiator.sv
// Single-outstanding bus initiator for the data Memory ren/wen/addr/din/dout port.
// Every access runs SETUP -> STROBE (WAIT_CYCLES) -> HOLD -> RESP so that addr/din never move under a strobe.
module memory_initiator #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BITS   = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("memory_initiator: WAIT_CYCLES=%0d is outside the legal range 1..255", WAIT_CYCLES);
  end

  localparam logic [7:0] COUNT_LOAD = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t      state;
  logic        write_q;
  logic        error_q;
  logic [7:0]  count;
  logic [31:0] rdata_q;
  logic        addr_in_range;

  assign addr_in_range = ~|(req_addr >> ADDR_BITS);

  // mem_addr/mem_din load only on the accept edge, so they are stable across SETUP/STROBE/HOLD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      error_q  <= 1'b0;
      count    <= 8'd0;
      rdata_q  <= 32'd0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            error_q  <= ~addr_in_range;
            rdata_q  <= 32'd0;
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            state    <= addr_in_range ? SETUP : RESP;
          end
        end
        SETUP: begin
          count <= COUNT_LOAD;
          state <= STROBE;
        end
        STROBE: begin
          if (count == 8'd0) begin
            if (!write_q) rdata_q <= mem_dout;
            state <= HOLD;
          end else begin
            count <= count - 8'd1;
          end
        end
        HOLD:    state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and handshake outputs decode only registered state, so reset drops them at once.
  assign req_ready = (state == IDLE);
  assign mem_ren   = (state == STROBE) && !write_q;
  assign mem_wen   = (state == STROBE) &&  write_q;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (state == RESP) ? rdata_q : 32'd0;
  assign rsp_error = (state == RESP) && error_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(mem_ren && mem_wen))
        else $error("memory_initiator: mem_ren and mem_wen asserted together");
    end
  end

endmodule

// File: tb/tb_memory_initiator.sv
// Directed bench for memory_initiator: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3,
// each attached to a small 16-word memory model with combinational read and clocked write.
module tb_memory_initiator;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  logic        req_valid_a = 1'b0, req_write_a = 1'b0;
  logic [31:0] req_addr_a = '0, req_wdata_a = '0;
  logic        req_ready_a, rsp_valid_a, rsp_error_a, mem_ren_a, mem_wen_a;
  logic [31:0] rsp_rdata_a, mem_addr_a, mem_din_a, mem_dout_a;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0;
  logic [31:0] req_addr_b = '0, req_wdata_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_error_b, mem_ren_b, mem_wen_b;
  logic [31:0] rsp_rdata_b, mem_addr_b, mem_din_b, mem_dout_b;

  logic [31:0] mem_a [16] = '{7: 32'hCAFEF00D, default: 32'h0};
  logic [31:0] mem_b [16] = '{default: 32'h0};

  always @(posedge clock) if (mem_wen_a) mem_a[mem_addr_a[3:0]] <= mem_din_a;
  always @(posedge clock) if (mem_wen_b) mem_b[mem_addr_b[3:0]] <= mem_din_b;
  assign mem_dout_a = mem_a[mem_addr_a[3:0]];
  assign mem_dout_b = mem_b[mem_addr_b[3:0]];

  memory_initiator #(.WAIT_CYCLES(1), .ADDR_BITS(12)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_error(rsp_error_a),
    .mem_addr(mem_addr_a), .mem_ren(mem_ren_a), .mem_wen(mem_wen_a),
    .mem_din(mem_din_a), .mem_dout(mem_dout_a)
  );

  memory_initiator #(.WAIT_CYCLES(3), .ADDR_BITS(12)) dut_wait3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_error(rsp_error_b),
    .mem_addr(mem_addr_b), .mem_ren(mem_ren_b), .mem_wen(mem_wen_b),
    .mem_din(mem_din_b), .mem_dout(mem_dout_b)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Full WAIT_CYCLES=1 access on the first instance, checked cycle by cycle from accept.
  task automatic apply_stimulus(input string tag, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata_exp);
    req_valid_a = 1'b1; req_write_a = write; req_addr_a = addr; req_wdata_a = wdata;
    check_output({tag, " ready c0"}, req_ready_a, 1);
    next_cycle();
    req_valid_a = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_output($sformatf("%s ren c%0d", tag, c), mem_ren_a, (!write && c == 2));
      check_output($sformatf("%s wen c%0d", tag, c), mem_wen_a, (write && c == 2));
      check_output($sformatf("%s rsp_valid c%0d", tag, c), rsp_valid_a, (c == 4));
      check_output($sformatf("%s rsp_rdata c%0d", tag, c), rsp_rdata_a, (c == 4) ? rdata_exp : 32'h0);
      check_output($sformatf("%s rsp_error c%0d", tag, c), rsp_error_a, 0);
      check_output($sformatf("%s ready c%0d", tag, c), req_ready_a, (c == 5));
      if (c <= 3) begin
        check_output($sformatf("%s mem_addr c%0d", tag, c), mem_addr_a, addr);
        check_output($sformatf("%s mem_din c%0d", tag, c), mem_din_a, wdata);
      end
      if (c < 5) next_cycle();
    end
  endtask

  initial begin
    #1;
    check_output("reset ready", req_ready_a, 1);
    check_output("reset rsp_valid", rsp_valid_a, 0);
    check_output("reset rsp_rdata", rsp_rdata_a, 0);
    check_output("reset rsp_error", rsp_error_a, 0);
    check_output("reset mem_ren", mem_ren_a, 0);
    check_output("reset mem_wen", mem_wen_a, 0);
    check_output("reset mem_addr", mem_addr_a, 0);
    check_output("reset mem_din", mem_din_a, 0);
    check_output("reset ready w3", req_ready_b, 1);
    #11 reset = 1'b0;
    next_cycle();

    apply_stimulus("wr5", 1'b1, 32'd5, 32'hDEADBEEF, 32'h0);
    check_output("mem word 5", mem_a[5], 32'hDEADBEEF);
    next_cycle();
    apply_stimulus("rd5", 1'b0, 32'd5, 32'h0, 32'hDEADBEEF);
    next_cycle();

    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 32'h0000_1000; req_wdata_a = 32'h0;
    next_cycle();
    req_valid_a = 1'b0;
    check_output("oor rsp_valid c1", rsp_valid_a, 1);
    check_output("oor rsp_error c1", rsp_error_a, 1);
    check_output("oor rsp_rdata c1", rsp_rdata_a, 0);
    check_output("oor ren c1", mem_ren_a, 0);
    check_output("oor wen c1", mem_wen_a, 0);
    check_output("oor ready c1", req_ready_a, 0);
    next_cycle();
    check_output("oor rsp_valid c2", rsp_valid_a, 0);
    check_output("oor rsp_error c2", rsp_error_a, 0);
    check_output("oor ready c2", req_ready_a, 1);
    check_output("oor ren c2", mem_ren_a, 0);

    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 32'd7; req_wdata_a = 32'h12345678;
    next_cycle();
    req_valid_a = 1'b0;
    next_cycle();
    check_output("abort wen strobe", mem_wen_a, 1);
    #2 reset = 1'b1;
    #1;
    check_output("abort wen reset", mem_wen_a, 0);
    check_output("abort ready reset", req_ready_a, 1);
    check_output("abort mem_addr reset", mem_addr_a, 0);
    check_output("abort rsp_valid reset", rsp_valid_a, 0);
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      check_output($sformatf("abort no rsp %0d", c), rsp_valid_a, 0);
    end
    check_output("abort mem word 7", mem_a[7], 32'hCAFEF00D);
    apply_stimulus("rd7", 1'b0, 32'd7, 32'h0, 32'hCAFEF00D);
    next_cycle();

    // WAIT_CYCLES=3: write then read with req_valid held high across both transactions.
    req_valid_b = 1'b1; req_write_b = 1'b1; req_addr_b = 32'd9; req_wdata_b = 32'h0BADF00D;
    check_output("w3 ready c0", req_ready_b, 1);
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      if (c == 1) begin req_write_b = 1'b0; req_wdata_b = 32'h0; end
      if (c == 8) req_valid_b = 1'b0;
      check_output($sformatf("w3 wen c%0d", c), mem_wen_b, (c >= 2 && c <= 4));
      check_output($sformatf("w3 ren c%0d", c), mem_ren_b, (c >= 9 && c <= 11));
      check_output($sformatf("w3 exclusive c%0d", c), (mem_ren_b && mem_wen_b), 0);
      check_output($sformatf("w3 rsp_valid c%0d", c), rsp_valid_b, (c == 6 || c == 13));
      check_output($sformatf("w3 ready c%0d", c), req_ready_b, (c == 7 || c == 14));
      check_output($sformatf("w3 rsp_rdata c%0d", c), rsp_rdata_b, (c == 13) ? 32'h0BADF00D : 32'h0);
      check_output($sformatf("w3 rsp_error c%0d", c), rsp_error_b, 0);
    end
    check_output("w3 mem word 9", mem_b[9], 32'h0BADF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
